block_receiver: RTL

BLOCK_RECEIVER -- requirements
Module: block_receiver

---
 rtl/block_receiver_if.sv | 27 ++
 rtl/block_receiver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/block_receiver_if.sv
// Dispatch <-> core block handshake: block start/reset and thread info in, launch/done status out.
interface block_receiver_if #(
    parameter int unsigned THREADS_PER_BLOCK = 4
) ();
    localparam int unsigned CountW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                           start;
    logic                           soft_reset;
    logic [7:0]                     block_id;
    logic [CountW-1:0]              thread_count;
    logic [THREADS_PER_BLOCK-1:0]   thread_retire;
    logic                           launch;
    logic [THREADS_PER_BLOCK-1:0]   thread_enable;
    logic [8*THREADS_PER_BLOCK-1:0] thread_id;
    logic                           done;
    logic                           timeout;

    modport master (
        output start, soft_reset, block_id, thread_count, thread_retire,
        input  launch, thread_enable, thread_id, done, timeout
    );

    modport slave (
        input  start, soft_reset, block_id, thread_count, thread_retire,
        output launch, thread_enable, thread_id, done, timeout
    );
endinterface

// File: rtl/block_receiver.sv
// Per-core block receiver: captures a dispatched block, launches its threads, tracks retirement.
// Optional RUN watchdog built only when BLOCK_RECEIVER_TIMEOUT_EN is defined.
module block_receiver #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input logic            clk,
    input logic            reset_n,
    block_receiver_if.slave bus
);
    localparam int unsigned T = THREADS_PER_BLOCK;

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [T-1:0]   enable_q, enable_d;
    logic [8*T-1:0] id_q, id_d;
    logic [T-1:0]   retired_q, retired_d;
    logic [T-1:0]   retire_all;
    logic [T-1:0]   cap_mask;
    logic [8*T-1:0] cap_ids;

`ifdef BLOCK_RECEIVER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Counts above T need no explicit clamp: slot i < T is live iff i < thread_count.
    always_comb begin
        cap_mask = '0;
        cap_ids  = '0;
        for (int i = 0; i < T; i++) begin
            cap_mask[i]       = (int'(bus.thread_count) > i);
            cap_ids[8*i +: 8] = 8'((int'(bus.block_id) * int'(T) + i) % 256);
        end
    end

    assign retire_all = retired_q | (bus.thread_retire & enable_q);

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        id_d      = id_q;
        retired_d = retired_q;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    enable_d = cap_mask;
                    id_d     = cap_ids;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                retired_d = '0;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d   = (|enable_q) ? StRun : StDone;
            end
            StRun: begin
                retired_d = retire_all;
                if (retire_all == enable_q) begin
                    state_d = StDone;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
                end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        // Soft reset overrides any capture, retire or watchdog activity this cycle.
        if (bus.soft_reset) begin
            state_d   = StIdle;
            enable_d  = '0;
            id_d      = '0;
            retired_d = '0;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            enable_q  <= '0;
            id_q      <= '0;
            retired_q <= '0;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            id_q      <= id_d;
            retired_q <= retired_d;
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // A zero-thread block passes through LAUNCH silently on its way to DONE.
    assign bus.launch        = (state_q == StLaunch) && (|enable_q);
    assign bus.thread_enable = enable_q;
    assign bus.thread_id     = id_q;
    assign bus.done          = (state_q == StDone);
`ifdef BLOCK_RECEIVER_TIMEOUT_EN
    assign bus.timeout       = timeout_q;
`else
    assign bus.timeout       = 1'b0;
`endif
endmodule
